// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   HDR_W                  : width of the word-count header (16)
//   WORD_W                 : instruction word width (32)
//   DEFAULT_TIMEOUT_CYCLES : default idle limit between accepted bytes
//   state_t                : loader FSM state encoding (S_CHECK is only
//                            reachable when IMEM_LOADER_CHECKSUM_EN is defined)
package imem_loader_pkg;

    localparam int HDR_W                  = 16;
    localparam int WORD_W                 = 32;
    localparam int DEFAULT_TIMEOUT_CYCLES = 50_000_000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR_HI = 3'd1,
        S_HDR_LO = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6,
        S_CHECK  = 3'd7
    } state_t;

endpackage

// File: rtl/imem_loader_timeout.sv
// Idle-cycle watchdog for the loader.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   clear        : zero the counter this cycle (byte accepted / not counting)
//   enable       : count this cycle
//   expired      : the counter sits at TIMEOUT_CYCLES-1 and another idle
//                  cycle is elapsing, so the limit is reached at this edge
// TIMEOUT_CYCLES must be at least 2.
module imem_loader_timeout #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_reg;

    // Saturates at LIMIT so the counter can never wrap if the FSM lingers.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != LIMIT)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = enable && !clear && (count_reg == LIMIT);

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: fills program memory from a byte stream before
// the CPU runs. Stream format: 16-bit big-endian word count, then that many
// big-endian 32-bit words, written to word addresses 0,1,2,...
// Optional build macro IMEM_LOADER_CHECKSUM_EN: a trailing byte equal to the
// XOR of all data bytes must follow the data, otherwise the load errors.
// Ports:
//   clock, reset        : clock and synchronous active-high reset
//   start               : single-cycle load request (IDLE/DONE/ERROR only)
//   rx_valid, rx_byte   : incoming byte stream
//   rx_ready            : byte transfers when rx_valid && rx_ready
//   mem_we, mem_addr,
//   mem_wdata           : one-cycle word write into instruction memory
//   cpu_hold            : CPU reset request, high while loading or on error
//   done, error         : load outcome levels
//   word_count          : words written so far in this load
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH     = 14,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_byte,
    output logic                  rx_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_W-1:0]     mem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [HDR_W-1:0]      word_count
);

    // Depth held one bit wider than the header so DEPTH = 65536 still compares.
    localparam logic [HDR_W:0] DEPTH_W = (HDR_W + 1)'(2 ** ADDR_WIDTH);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t S_AFTER_DATA = S_CHECK;
`else
    localparam state_t S_AFTER_DATA = S_DONE;
`endif

    state_t                state_reg, state_next;
    logic [HDR_W-1:0]      len_reg, len_next;
    logic [HDR_W-1:0]      word_count_reg, word_count_next;
    logic [WORD_W-1:0]     word_reg, word_next;
    logic [1:0]            byte_idx_reg, byte_idx_next;
    logic [ADDR_WIDTH-1:0] last_addr_reg, last_addr_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]            csum_reg, csum_next;
`endif

    logic             counting;
    logic             tmo_clear;
    logic             tmo_expired;
    logic [HDR_W-1:0] hdr_len;
    logic [HDR_W-1:0] word_count_inc;

    // States that accept bytes are exactly the states the watchdog covers.
    assign counting = (state_reg == S_HDR_HI) || (state_reg == S_HDR_LO) ||
`ifdef IMEM_LOADER_CHECKSUM_EN
                      (state_reg == S_CHECK) ||
`endif
                      (state_reg == S_DATA);

    assign rx_ready  = counting;
    assign tmo_clear = !counting || rx_valid;

    imem_loader_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clock  (clock),
        .reset  (reset),
        .clear  (tmo_clear),
        .enable (counting),
        .expired(tmo_expired)
    );

    assign hdr_len        = {len_reg[HDR_W-1:8], rx_byte};
    assign word_count_inc = word_count_reg + 1'b1;

    // During WRITE the address is the pre-increment count; afterwards the
    // last written address is held.
    assign mem_addr   = (state_reg == S_WRITE) ? word_count_reg[ADDR_WIDTH-1:0]
                                               : last_addr_reg;
    assign mem_wdata  = word_reg;
    assign word_count = word_count_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            len_reg        <= '0;
            word_count_reg <= '0;
            word_reg       <= '0;
            byte_idx_reg   <= '0;
            last_addr_reg  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_reg       <= '0;
`endif
        end else begin
            state_reg      <= state_next;
            len_reg        <= len_next;
            word_count_reg <= word_count_next;
            word_reg       <= word_next;
            byte_idx_reg   <= byte_idx_next;
            last_addr_reg  <= last_addr_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_reg       <= csum_next;
`endif
        end
    end

    always_comb begin
        state_next      = state_reg;
        len_next        = len_reg;
        word_count_next = word_count_reg;
        word_next       = word_reg;
        byte_idx_next   = byte_idx_reg;
        last_addr_next  = last_addr_reg;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_next       = csum_reg;
`endif
        mem_we   = 1'b0;
        cpu_hold = 1'b0;
        done     = 1'b0;
        error    = 1'b0;

        case (state_reg)
            S_IDLE, S_DONE, S_ERROR: begin
                done     = (state_reg == S_DONE);
                error    = (state_reg == S_ERROR);
                cpu_hold = (state_reg == S_ERROR);
                if (start) begin
                    state_next      = S_HDR_HI;
                    word_count_next = '0;
                    byte_idx_next   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_next       = '0;
`endif
                end
            end

            S_HDR_HI: begin
                cpu_hold = 1'b1;
                if (rx_valid) begin
                    len_next[HDR_W-1:8] = rx_byte;
                    state_next          = S_HDR_LO;
                end else if (tmo_expired) begin
                    state_next = S_ERROR;
                end
            end

            S_HDR_LO: begin
                cpu_hold = 1'b1;
                if (rx_valid) begin
                    len_next[7:0] = rx_byte;
                    if ({1'b0, hdr_len} > DEPTH_W) begin
                        state_next = S_ERROR;
                    end else if (hdr_len == '0) begin
                        state_next = S_AFTER_DATA;
                    end else begin
                        state_next = S_DATA;
                    end
                end else if (tmo_expired) begin
                    state_next = S_ERROR;
                end
            end

            S_DATA: begin
                cpu_hold = 1'b1;
                if (rx_valid) begin
                    // Shifting in from the bottom leaves byte 0 in [31:24].
                    word_next     = {word_reg[WORD_W-9:0], rx_byte};
                    byte_idx_next = byte_idx_reg + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_next     = csum_reg ^ rx_byte;
`endif
                    if (byte_idx_reg == 2'd3) begin
                        state_next = S_WRITE;
                    end
                end else if (tmo_expired) begin
                    state_next = S_ERROR;
                end
            end

            S_WRITE: begin
                cpu_hold        = 1'b1;
                mem_we          = 1'b1;
                word_count_next = word_count_inc;
                last_addr_next  = word_count_reg[ADDR_WIDTH-1:0];
                state_next      = (word_count_inc == len_reg) ? S_AFTER_DATA : S_DATA;
            end

`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                cpu_hold = 1'b1;
                if (rx_valid) begin
                    state_next = (rx_byte == csum_reg) ? S_DONE : S_ERROR;
                end else if (tmo_expired) begin
                    state_next = S_ERROR;
                end
            end
`endif

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule
